// File: rtl/mode_encoder.sv
// mode_encoder: registered one-hot / priority / round-robin encoder with valid-ready handshake
// Ports: clk; rst_n (async, active low); in_valid/in_ready/A/mode form the input handshake;
//        out_valid/out_ready/O/hit/count form the registered result handshake.
module mode_encoder #(
   parameter int N = 8,
   localparam int W = (N > 1) ? $clog2(N) : 1,
   localparam int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  A,
   input  logic [1:0]    mode,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  O,
   output logic          hit,
   output logic [CW-1:0] count
);
   logic [W-1:0] ptr_q, ptr_d, o_q, o_d, hi, lo, rr;
   logic [CW-1:0] count_q, count_d;
   logic hit_q, hit_d, valid_q, valid_d, cap;
   int j;
   assign in_ready = !valid_q || out_ready;
   assign cap = in_valid && in_ready;
   always_comb begin
      count_d = '0;
      hi = '0;
      lo = '0;
      rr = '0;
      j = 0;
      for (int i = 0; i < N; i++) begin
         count_d = count_d + CW'(A[i]);
         if (A[i]) hi = W'(i);
      end
      // descending scans: the last match written is the first one in search order
      for (int i = N - 1; i >= 0; i--) begin
         if (A[i]) lo = W'(i);
         j = int'(ptr_q) + i;
         j = (j >= N) ? j - N : j;
         if (A[j]) rr = W'(j);
      end
      hit_d = (mode == 2'b00) ? (count_d == CW'(1)) : (count_d != '0);
      o_d = (mode == 2'b00) ? (hit_d ? lo : '0) :
            (mode == 2'b01) ? hi :
            (mode == 2'b10) ? lo : rr;
      ptr_d = (cap && mode == 2'b11 && hit_d) ? ((rr == W'(N - 1)) ? '0 : rr + W'(1)) : ptr_q;
      valid_d = cap ? 1'b1 : (out_ready ? 1'b0 : valid_q);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
         o_q <= '0;
         hit_q <= 1'b0;
         count_q <= '0;
         valid_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         valid_q <= valid_d;
         if (cap) begin
            o_q <= o_d;
            hit_q <= hit_d;
            count_q <= count_d;
         end
      end
   end
   assign out_valid = valid_q;
   assign O = o_q;
   assign hit = hit_q;
   assign count = count_q;
endmodule

// File: tb/tb_mode_encoder.sv
// tb_mode_encoder: table-driven and scoreboard checks of mode_encoder at N=8 and N=5
module tb_mode_encoder;
   logic clk = 1'b0;
   logic rst_n;
   logic iv8, ir8, ov8, or8, h8;
   logic [7:0] a8;
   logic [1:0] m8;
   logic [2:0] o8;
   logic [3:0] cn8;
   logic iv5, ir5, ov5, or5, h5;
   logic [4:0] a5;
   logic [1:0] m5;
   logic [2:0] o5;
   logic [2:0] cn5;
   int checks = 0;
   int errors = 0;
   typedef struct {
      logic [2:0] o;
      logic h;
      logic [3:0] c;
   } exp_t;
   typedef struct {
      logic [7:0] a;
      logic [1:0] m;
      logic [2:0] o;
      logic h;
      logic [3:0] c;
   } vec_t;
   exp_t q8[$];
   exp_t q5[$];
   vec_t tbl[17];
   always #5 clk = ~clk;
   mode_encoder #(.N(8)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .mode(m8),
      .out_valid(ov8), .out_ready(or8), .O(o8), .hit(h8), .count(cn8)
   );
   mode_encoder #(.N(5)) u5 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv5), .in_ready(ir5), .A(a5), .mode(m5),
      .out_valid(ov5), .out_ready(or5), .O(o5), .hit(h5), .count(cn5)
   );
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   task automatic tick();
      logic c8, c5;
      exp_t e;
      c8 = iv8 && ir8;
      c5 = iv5 && ir5;
      @(posedge clk);
      #1;
      if (c8) begin
         if (q8.size() == 0) chk("q8_empty", 0, 1);
         else begin
            e = q8.pop_front();
            chk("valid8", 32'(ov8), 1);
            chk("o8", 32'(o8), 32'(e.o));
            chk("hit8", 32'(h8), 32'(e.h));
            chk("count8", 32'(cn8), 32'(e.c));
         end
      end
      if (c5) begin
         if (q5.size() == 0) chk("q5_empty", 0, 1);
         else begin
            e = q5.pop_front();
            chk("valid5", 32'(ov5), 1);
            chk("o5", 32'(o5), 32'(e.o));
            chk("hit5", 32'(h5), 32'(e.h));
            chk("count5", 32'(cn5), 32'(e.c));
         end
      end
   endtask
   task automatic drv8(input logic [7:0] a, input logic [1:0] m, input logic orv,
                       input logic [2:0] eo, input logic eh, input logic [3:0] ec);
      exp_t e;
      iv8 = 1'b1;
      a8 = a;
      m8 = m;
      or8 = orv;
      #1;
      e.o = eo;
      e.h = eh;
      e.c = ec;
      if (ir8) q8.push_back(e);
      tick();
   endtask
   task automatic drv5(input logic [4:0] a, input logic [1:0] m,
                       input logic [2:0] eo, input logic eh, input logic [3:0] ec);
      exp_t e;
      iv5 = 1'b1;
      a5 = a;
      m5 = m;
      or5 = 1'b1;
      #1;
      e.o = eo;
      e.h = eh;
      e.c = ec;
      if (ir5) q5.push_back(e);
      tick();
   endtask
   initial begin
      tbl[0]  = '{8'h10, 2'd0, 3'd4, 1'b1, 4'd1};
      tbl[1]  = '{8'h12, 2'd0, 3'd0, 1'b0, 4'd2};
      tbl[2]  = '{8'h12, 2'd1, 3'd4, 1'b1, 4'd2};
      tbl[3]  = '{8'h12, 2'd2, 3'd1, 1'b1, 4'd2};
      tbl[4]  = '{8'h00, 2'd1, 3'd0, 1'b0, 4'd0};
      tbl[5]  = '{8'h00, 2'd0, 3'd0, 1'b0, 4'd0};
      tbl[6]  = '{8'h80, 2'd0, 3'd7, 1'b1, 4'd1};
      tbl[7]  = '{8'hFF, 2'd1, 3'd7, 1'b1, 4'd8};
      tbl[8]  = '{8'hFF, 2'd2, 3'd0, 1'b1, 4'd8};
      tbl[9]  = '{8'h24, 2'd3, 3'd2, 1'b1, 4'd2};
      tbl[10] = '{8'h24, 2'd3, 3'd5, 1'b1, 4'd2};
      tbl[11] = '{8'h24, 2'd3, 3'd2, 1'b1, 4'd2};
      tbl[12] = '{8'h00, 2'd3, 3'd0, 1'b0, 4'd0};
      tbl[13] = '{8'h01, 2'd1, 3'd0, 1'b1, 4'd1};
      tbl[14] = '{8'h09, 2'd3, 3'd3, 1'b1, 4'd2};
      tbl[15] = '{8'h81, 2'd3, 3'd7, 1'b1, 4'd2};
      tbl[16] = '{8'h81, 2'd3, 3'd0, 1'b1, 4'd2};
      rst_n = 1'b0;
      iv8 = 1'b0; a8 = '0; m8 = '0; or8 = 1'b0;
      iv5 = 1'b0; a5 = '0; m5 = '0; or5 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid8", 32'(ov8), 0);
      chk("rst_o8", 32'(o8), 0);
      chk("rst_hit8", 32'(h8), 0);
      chk("rst_count8", 32'(cn8), 0);
      chk("rst_ready8", 32'(ir8), 1);
      chk("rst_valid5", 32'(ov5), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 17; i++) drv8(tbl[i].a, tbl[i].m, 1'b1, tbl[i].o, tbl[i].h, tbl[i].c);
      iv8 = 1'b0;
      tick();
      chk("drain_valid8", 32'(ov8), 0);
      for (int i = 0; i < 6; i++) drv5(5'h1F, 2'd3, 3'((i == 5) ? 0 : i), 1'b1, 4'd5);
      drv5(5'h01, 2'd3, 3'd0, 1'b1, 4'd1);
      drv5(5'h10, 2'd0, 3'd4, 1'b1, 4'd1);
      drv5(5'h06, 2'd3, 3'd1, 1'b1, 4'd2);
      iv5 = 1'b0;
      drv8(8'h40, 2'd2, 1'b1, 3'd6, 1'b1, 4'd1);
      for (int i = 0; i < 3; i++) begin
         iv8 = 1'b1;
         or8 = 1'b0;
         a8 = 8'(i + 8'hA5);
         m8 = 2'(i);
         #1;
         chk("stall_ready8", 32'(ir8), 0);
         tick();
         chk("stall_valid8", 32'(ov8), 1);
         chk("stall_o8", 32'(o8), 6);
         chk("stall_count8", 32'(cn8), 1);
      end
      drv8(8'h03, 2'd1, 1'b1, 3'd1, 1'b1, 4'd2);
      chk("overlap_valid8", 32'(ov8), 1);
      drv8(8'h04, 2'd3, 1'b1, 3'd2, 1'b1, 4'd1);
      iv8 = 1'b0;
      or8 = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid8", 32'(ov8), 0);
      chk("arst_o8", 32'(o8), 0);
      chk("arst_hit8", 32'(h8), 0);
      chk("arst_count8", 32'(cn8), 0);
      chk("arst_ready8", 32'(ir8), 1);
      q8.delete();
      q5.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      drv8(8'hFF, 2'd3, 1'b1, 3'd0, 1'b1, 4'd8);
      drv8(8'hFF, 2'd3, 1'b1, 3'd1, 1'b1, 4'd8);
      iv8 = 1'b0;
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mode_encoder.md
MODE_ENCODER -- requirements
Module: mode_encoder

Interface
REQ-001 SHALL have parameter N, default 8: number of request lines; legal range 1..64, any value, power of two not required.
REQ-002 SHALL derive localparam W = (N>1) ? clog2(N) : 1 as the index width, and localparam CW = clog2(N+1) as the count width.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: request vector A and mode are valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept A this cycle.
REQ-007 SHALL have port A, input, N bits: request vector.
REQ-008 SHALL have port mode, input, 2 bits: 00 strict one-hot, 01 priority-high, 10 priority-low, 11 round-robin.
REQ-009 SHALL have port out_valid, output, 1 bit: result registers hold an unconsumed result.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port O, output, W bits: encoded index.
REQ-012 SHALL have port hit, output, 1 bit: O is a meaningful index for the sampled mode.
REQ-013 SHALL have port count, output, CW bits: number of set bits in the captured A.

Function
REQ-014 SHALL capture A and mode on a rising edge when in_valid && in_ready (the input handshake).
REQ-015 SHALL drive in_ready = !out_valid || out_ready combinationally, giving a single output register with no bubble.
REQ-016 SHALL present O, hit and count with out_valid = 1 exactly one cycle after capture; latency is 1.
REQ-017 SHALL hold O, hit, count and out_valid stable while out_valid && !out_ready.
REQ-018 SHALL clear out_valid on out_valid && out_ready when no new capture occurs in the same cycle.
REQ-019 SHALL, on simultaneous output acceptance and new capture, keep out_valid at 1 and load the new result.
REQ-020 SHALL in mode 00 set hit = 1 and O = index of the set bit only when count == 1; otherwise hit = 0 and O = 0.
REQ-021 SHALL in mode 01 set O = highest set index and hit = (count != 0).
REQ-022 SHALL in mode 10 set O = lowest set index and hit = (count != 0).
REQ-023 SHALL in mode 11 set O = first set index found searching upward from ptr, wrapping from N-1 to 0, with hit = (count != 0).
REQ-024 SHALL keep ptr as a W-bit internal register, reset value 0, and update it only on a capture with mode 11 and hit = 1.
REQ-025 SHALL on that update set ptr = O+1, or ptr = 0 when O == N-1; ptr never exceeds N-1 for non-power-of-two N.
REQ-026 SHALL, whenever A == 0 in any mode, produce hit = 0, O = 0, count = 0 and leave ptr unchanged.
REQ-027 SHALL leave ptr unchanged on captures in modes 00, 01 and 10.
REQ-028 SHALL ignore A[N-1:0] and mode when no capture occurs.
REQ-029 SHALL compute count as an exact popcount with no saturation; count = N when all bits are set.
REQ-030 SHALL, when N == 1, return O = 0 in every mode, with hit = A[0].

Reset
REQ-031 SHALL, when rst_n is low, asynchronously force out_valid = 0, O = 0, hit = 0, count = 0 and ptr = 0.
REQ-032 SHALL discard any pending result on reset mid-transfer; in_ready = 1 while reset is asserted and after release.
REQ-033 SHALL perform the first capture on the first rising edge after rst_n deasserts, given in_valid = 1.

Verification
REQ-034 Bench SHALL cover: N=8, mode 00, A=0x10 -> one cycle later out_valid=1, O=4, hit=1, count=1; A=0x12 -> O=0, hit=0, count=2.
REQ-035 Bench SHALL cover: N=8, A=0x12 in mode 01 -> O=4; the same A in mode 10 -> O=1; A=0x00 -> hit=0, O=0, count=0.
REQ-036 Bench SHALL cover: N=5, mode 11, A=0x1F repeated 6 times with out_ready=1 -> O sequence 0,1,2,3,4,0 and ptr wraps at 4.
REQ-037 Bench SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, result held stable; then out_ready=1 -> the next A is captured in the same cycle and out_valid stays 1.
REQ-038 Bench SHALL cover: rst_n pulled low while out_valid=1 and ptr=3 -> out_valid, O, hit and count go to 0 immediately; after release, mode 11 with A=0xFF -> O=0.
